// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage sitting directly upstream of decode.
//
// This block owns the program counter and issues sequential word reads to an
// instruction memory with a fixed one-cycle read latency. Each returned word is
// pushed with its address into a small FIFO. Decode can therefore stall without
// losing an instruction that is already in flight. Redirects flush the FIFO and
// restart fetching at the new address in the same cycle.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to an address whose bits [1:0] are not 00 sets the
//               sticky misalign flag, flushes the FIFO and halts fetching until
//               reset.
//   undefined : redirect_pc[1:0] is ignored and misalign stays 0.
//
// Parameters:
//   RESET_PC      first fetch address after reset
//   DEPTH         FIFO entries (2, 4 or 8)
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   stall         decode cannot accept the head entry this cycle
//   redirect      flush and restart at redirect_pc
//   redirect_pc   new fetch address
//   imem_rd       read strobe to instruction memory
//   imem_addr     word address of the read (bits [1:0] always 00)
//   imem_data     read data, valid one cycle after imem_rd
//   insn          head instruction (0 when the FIFO is empty)
//   pc            address of the head instruction (0 when the FIFO is empty)
//   enable_decode head entry is valid and offered to decode
//   misalign      sticky misaligned-redirect flag
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        enable_decode,
  output logic        misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] FULL_OCC = (CW + 1)'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [31:0]    req_pc;
  logic           inflight;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [31:0]    insn_q [DEPTH];
  logic [31:0]    pc_q   [DEPTH];

  logic           run;
  logic [31:0]    target_pc;
  logic           bad_target;
  logic           redir_ok;
  logic           redir_bad;
  logic           has_head;
  logic           pop;
  logic [CW:0]    occ;
  logic           issue_seq;
  logic           issue;
  logic           wr;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    target_pc  = redirect_pc;
    bad_target = |redirect_pc[1:0];
`else
    target_pc  = redirect_pc & 32'hFFFF_FFFC;
    bad_target = 1'b0;
`endif
    run       = (state == RUN);
    redir_ok  = run & redirect & ~bad_target;
    redir_bad = run & redirect & bad_target;

    has_head      = (count != '0);
    enable_decode = run & has_head & ~redirect;
    pop           = enable_decode & ~stall;

    // Issue budget counts the in-flight response, so a full FIFO plus an
    // outstanding read can never produce a write past DEPTH. When the budget
    // is exactly used up, a pop this cycle frees the slot the new read needs.
    occ       = {1'b0, count} + (CW + 1)'(inflight);
    issue_seq = run & ~redirect & ((occ < FULL_OCC) | ((occ == FULL_OCC) & pop));
    issue     = ~reset & (redir_ok | issue_seq);

    imem_rd   = issue;
    imem_addr = issue ? (redir_ok ? target_pc : fetch_pc) : '0;

    // A response landing in a redirect cycle belongs to the old stream.
    wr = run & inflight & ~redirect;

    insn = has_head ? insn_q[rd_ptr] : '0;
    pc   = has_head ? pc_q[rd_ptr]   : '0;
  end

  // Control state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      misalign <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= (redir_ok ? target_pc : fetch_pc) + 32'd4;
      end
      if (redir_ok || redir_bad) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (redir_bad) begin
          state    <= HALT;
          misalign <= 1'b1;
        end
      end else begin
        if (wr) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  // Data path: request address and FIFO storage carry no reset
  always_ff @(posedge clock) begin
    if (issue) begin
      req_pc <= imem_addr;
    end
    if (wr) begin
      insn_q[wr_ptr] <= imem_data;
      pc_q[wr_ptr]   <= req_pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(wr && !pop && count == FULL_OCC[CW-1:0]))
        else $error("fetch_buffer: FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer (DEPTH = 2, RESET_PC = 8002_0000).
// Memory model returns addr ^ A5A5_A5A5 one cycle after each read strobe and
// DEAD_BEEF otherwise. Inputs change 1 time unit after a rising edge, outputs
// are checked 3 time units after the rising edge.
module tb_fetch_buffer;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        enable_decode;
  logic        misalign;

  int n_cmp;
  int n_err;

  fetch_buffer #(
    .RESET_PC (32'h8002_0000),
    .DEPTH    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .insn          (insn),
    .pc            (pc),
    .enable_decode (enable_decode),
    .misalign      (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_rd) imem_data <= imem_addr ^ K;
    else         imem_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Advance to the next cycle and apply inputs, then let outputs settle.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #2;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_en"},   {31'd0, enable_decode}, 32'd1);
    chk({tag, "_pc"},   pc,   exp_pc);
    chk({tag, "_insn"}, insn, exp_pc ^ K);
  endtask

  task automatic chk_rd(input string tag, input logic exp_rd, input logic [31:0] exp_addr);
    chk({tag, "_rd"},   {31'd0, imem_rd}, {31'd0, exp_rd});
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_data   = 32'h0;
    #3;
    // Reset values
    chk("rst_rd",   {31'd0, imem_rd}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc",   pc, 32'd0);
    chk("rst_en",   {31'd0, enable_decode}, 32'd0);
    chk("rst_mis",  {31'd0, misalign}, 32'd0);

    // Cycle 0: release reset
    @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    chk_rd("c0", 1'b1, 32'h8002_0000);
    chk("c0_en", {31'd0, enable_decode}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 1
    chk_rd("c1", 1'b1, 32'h8002_0004);
    chk("c1_en", {31'd0, enable_decode}, 32'd0);
    chk("c1_pc", pc, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 2
    chk_head("c2", 32'h8002_0000);
    chk_rd("c2", 1'b1, 32'h8002_0008);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 3
    chk_head("c3", 32'h8002_0004);
    chk_rd("c3", 1'b1, 32'h8002_000C);

    // Stall for 5 cycles on 8002_0008
    cyc(1'b1, 1'b0, 32'h0);                 // cycle 4
    chk_head("st0", 32'h8002_0008);
    chk_rd("st0", 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin       // cycles 5..8
      cyc(1'b1, 1'b0, 32'h0);
      chk_head("stn", 32'h8002_0008);
      chk_rd("stn", 1'b0, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 9
    chk_head("rel0", 32'h8002_0008);
    chk_rd("rel0", 1'b1, 32'h8002_0010);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 10
    chk_head("rel1", 32'h8002_000C);
    chk_rd("rel1", 1'b1, 32'h8002_0014);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 11
    chk_head("rel2", 32'h8002_0010);
    cyc(1'b0, 1'b0, 32'h0);                 // cycle 12
    chk_head("rel3", 32'h8002_0014);

    // Redirect with the issue budget used up and a response arriving
    cyc(1'b0, 1'b1, 32'h8002_1000);         // cycle R
    chk("rd_en", {31'd0, enable_decode}, 32'd0);
    chk_rd("rdR", 1'b1, 32'h8002_1000);
    cyc(1'b0, 1'b0, 32'h0);                 // R+1
    chk("rd1_en", {31'd0, enable_decode}, 32'd0);
    chk_rd("rd1", 1'b1, 32'h8002_1004);
    cyc(1'b0, 1'b0, 32'h0);                 // R+2
    chk_head("rd2", 32'h8002_1000);
    cyc(1'b0, 1'b0, 32'h0);                 // R+3
    chk_head("rd3", 32'h8002_1004);

    // Redirect near the top of the address space: fetch_pc wraps to 0
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
    chk_rd("wrR", 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, 32'h0);
    chk_rd("wr1", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("wr2", 32'hFFFF_FFF8);
    chk_rd("wr2", 1'b1, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("wr3", 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("wr4", 32'h0000_0000);

    // Misaligned redirect
    cyc(1'b0, 1'b1, 32'h8002_0002);
    chk("ma_en", {31'd0, enable_decode}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk_rd("maR", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, (i == 1), 32'h8002_0100);   // aligned redirect in HALT is ignored
      chk("ma_mis", {31'd0, misalign}, 32'd1);
      chk("ma_hen", {31'd0, enable_decode}, 32'd0);
      chk_rd("mah", 1'b0, 32'h0);
    end
`else
    chk_rd("maR", 1'b1, 32'h8002_0000);
    cyc(1'b0, 1'b0, 32'h0);
    chk("ma_mis", {31'd0, misalign}, 32'd0);
    chk_rd("ma1", 1'b1, 32'h8002_0004);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("ma2", 32'h8002_0000);
`endif

    // Mid-stream asynchronous reset while stalled
    cyc(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rd",   {31'd0, imem_rd}, 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    chk("ar_insn", insn, 32'd0);
    chk("ar_pc",   pc, 32'd0);
    chk("ar_en",   {31'd0, enable_decode}, 32'd0);
    chk("ar_mis",  {31'd0, misalign}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    #2;
    chk_rd("ar0", 1'b1, 32'h8002_0000);
    chk("ar0_en", {31'd0, enable_decode}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("ar1_en", {31'd0, enable_decode}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("ar2", 32'h8002_0000);
    cyc(1'b0, 1'b0, 32'h0);
    chk_head("ar3", 32'h8002_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
